// File: rtl/fire_expand1_weight_seq.sv
// Weight read sequencer for the fire expand-1x1 stage: sweeps the weight ROM
// pass_tgt times per start and streams each 64-lane slice under valid/ready.
module fire_expand1_weight_seq #(
    parameter int WIDTH  = 16,
    parameter int ADDR   = 4,
    parameter int NUM    = 64,
    parameter int DEPTH  = 16,
    parameter int PASS_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [PASS_W-1:0]           npass,
    output logic [ADDR-1:0]             rom_addr,
    input  logic [0:NUM-1][WIDTH-1:0]   rom_data,
    output logic [0:NUM-1][WIDTH-1:0]   w_out,
    output logic                        w_valid,
    input  logic                        w_ready,
    output logic                        w_sweep_end,
    output logic                        w_last,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [ADDR-1:0] ADDR_LAST = ADDR'(DEPTH - 1);

    state_t              state, state_nxt;
    logic [ADDR-1:0]     addr, addr_nxt;
    logic [PASS_W-1:0]   pass_cnt, pass_cnt_nxt;
    logic [PASS_W-1:0]   pass_tgt, pass_tgt_nxt;
    logic                load, at_last, final_sweep, accept;

    assign load        = !w_valid || w_ready;
    assign accept      = w_valid && w_ready;
    assign at_last     = (addr == ADDR_LAST);
    assign final_sweep = (pass_cnt == pass_tgt - PASS_W'(1));
    assign rom_addr    = addr;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            pass_cnt <= '0;
            pass_tgt <= PASS_W'(1);
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            pass_cnt <= pass_cnt_nxt;
            pass_tgt <= pass_tgt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr;
        pass_cnt_nxt = pass_cnt;
        pass_tgt_nxt = pass_tgt;
        case (state)
            IDLE: begin
                addr_nxt = '0;
                // The done cycle is still IDLE; a start landing on it must not launch a run.
                if (start && !done) begin
                    pass_tgt_nxt = (npass == '0) ? PASS_W'(1) : npass;
                    pass_cnt_nxt = '0;
                    state_nxt    = RUN;
                end
            end
            RUN: begin
                if (load) begin
                    if (!at_last) begin
                        addr_nxt = addr + ADDR'(1);
                    end else begin
                        addr_nxt = '0;
                        if (final_sweep) state_nxt = DRAIN;
                        else             pass_cnt_nxt = pass_cnt + PASS_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (accept) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output slice register: loads whenever the slot is empty or being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_out       <= '0;
            w_valid     <= 1'b0;
            w_sweep_end <= 1'b0;
            w_last      <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    if (load) begin
                        w_out       <= rom_data;
                        w_valid     <= 1'b1;
                        w_sweep_end <= at_last;
                        w_last      <= at_last && final_sweep;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        w_valid     <= 1'b0;
                        w_sweep_end <= 1'b0;
                        w_last      <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fire_expand1_weight_seq.sv
// Randomized bench for fire_expand1_weight_seq: a random ROM image is swept and
// each accepted beat is compared with the slice the sweep order predicts.
module tb_fire_expand1_weight_seq;

    localparam int WIDTH  = 16;
    localparam int ADDR   = 4;
    localparam int NUM    = 64;
    localparam int DEPTH  = 16;
    localparam int PASS_W = 16;

    typedef logic [0:NUM-1][WIDTH-1:0] slice_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [PASS_W-1:0]   npass;
    logic [ADDR-1:0]     rom_addr;
    slice_t              rom_data;
    slice_t              w_out;
    logic                w_valid;
    logic                w_ready;
    logic                w_sweep_end;
    logic                w_last;
    logic                busy;
    logic                done;

    slice_t rom_mem [0:(1<<ADDR)-1];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_mem[rom_addr];

    fire_expand1_weight_seq #(
        .WIDTH(WIDTH), .ADDR(ADDR), .NUM(NUM), .DEPTH(DEPTH), .PASS_W(PASS_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .npass(npass),
        .rom_addr(rom_addr), .rom_data(rom_data), .w_out(w_out),
        .w_valid(w_valid), .w_ready(w_ready), .w_sweep_end(w_sweep_end),
        .w_last(w_last), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One comparison per slice, reported on the first differing lane.
    task automatic chk_slice(input string tag, input slice_t obs, input slice_t exp);
        int j = 0;
        for (int i = NUM - 1; i >= 0; i--)
            if (obs[i] !== exp[i]) j = i;
        chk($sformatf("%s[%0d]", tag, j), 64'(obs[j]), 64'(exp[j]));
    endtask

    task automatic fill_rom();
        for (int a = 0; a < (1 << ADDR); a++)
            for (int l = 0; l < NUM; l++)
                rom_mem[a][l] = WIDTH'($urandom);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_rom_addr"}, 64'(rom_addr), 64'd0);
        chk_slice({nm, "_w_out"}, w_out, '0);
        chk({nm, "_w_valid"}, 64'(w_valid), 64'd0);
        chk({nm, "_w_sweep_end"}, 64'(w_sweep_end), 64'd0);
        chk({nm, "_w_last"}, 64'(w_last), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_done"}, 64'(done), 64'd0);
    endtask

    // One run: np sweeps, rdy_pct% ready, optional start while busy at beat
    // restart_at, optional reset drop once reset_at beats have been accepted.
    task automatic run(input int np, input int rdy_pct, input int restart_at,
                       input int reset_at, input string nm);
        int     tgt;
        int     total;
        int     beat = 0;
        int     busy_cnt = 0;
        int     cyc = 0;
        bit     stalled = 0;
        bit     finished = 0;
        slice_t hold_w = '0;
        logic   hold_se = 1'b0;
        logic   hold_l = 1'b0;
        tgt   = (np == 0) ? 1 : np;
        total = tgt * DEPTH;
        fill_rom();
        @(negedge clk);
        npass   = PASS_W'(np);
        start   = 1'b1;
        w_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy_rise"}, 64'(busy), 64'd1);
        chk({nm, "_valid_latency"}, 64'(w_valid), 64'd0);
        while (!finished && cyc < total * 20 + 40) begin
            if (busy) busy_cnt++;
            if (stalled) begin
                chk_slice({nm, "_hold_w"}, w_out, hold_w);
                chk({nm, "_hold_se"}, 64'(w_sweep_end), 64'(hold_se));
                chk({nm, "_hold_last"}, 64'(w_last), 64'(hold_l));
            end
            if (done) begin
                finished = 1;
                chk({nm, "_beats"}, 64'(beat), 64'(total));
                chk({nm, "_busy_fall"}, 64'(busy), 64'd0);
                chk({nm, "_valid_fall"}, 64'(w_valid), 64'd0);
                if (rdy_pct == 100)
                    chk({nm, "_busy_cycles"}, 64'(busy_cnt), 64'(total + 1));
                start = 1'b1;
                npass = PASS_W'(1);
                @(negedge clk);
                start = 1'b0;
                chk({nm, "_done_pulse"}, 64'(done), 64'd0);
                chk({nm, "_start_at_done"}, 64'(busy), 64'd0);
            end else begin
                start   = (beat == restart_at) && busy;
                w_ready = ($urandom_range(99) < rdy_pct);
                if (w_valid && w_ready) begin
                    chk_slice($sformatf("%s_b%0d_w", nm, beat), w_out, rom_mem[beat % DEPTH]);
                    chk($sformatf("%s_b%0d_se", nm, beat), 64'(w_sweep_end),
                        64'((beat % DEPTH) == DEPTH - 1));
                    chk($sformatf("%s_b%0d_last", nm, beat), 64'(w_last),
                        64'(beat == total - 1));
                    beat++;
                end
                stalled = w_valid && !w_ready;
                hold_w  = w_out;
                hold_se = w_sweep_end;
                hold_l  = w_last;
                if (reset_at >= 0 && beat == reset_at) begin
                    #2 rst_n = 1'b0;
                    #1 chk_all_zero({nm, "_async"});
                    @(negedge clk);
                    rst_n   = 1'b1;
                    start   = 1'b0;
                    w_ready = 1'b0;
                    return;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!finished) chk({nm, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        w_ready = 1'b0;
        npass   = '0;
        fill_rom();
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run(1, 100, -1, -1, "p1");
        run(3, 100, -1, -1, "p3");
        run(0, 100, -1, -1, "p0");
        run(2, 50, -1, -1, "rnd");
        run(1, 100, 5, -1, "restart");
        run(1, 100, -1, 7, "rst");
        run(1, 60, -1, -1, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
